// File: rtl/minesweeper_ctrl_if.sv
//----------------------------------------------------------------------------
// minesweeper_ctrl_if : button, field-filler and renderer signals of the
//                       minesweeper gameplay controller.
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

interface minesweeper_ctrl_if #(
  parameter int MAX_CELL_WIDTH  = 30,
  parameter int MAX_CELL_HEIGHT = 16
);
  localparam int CELL_X_WIDTH = $clog2(MAX_CELL_WIDTH);
  localparam int CELL_Y_WIDTH = $clog2(MAX_CELL_HEIGHT);
  localparam int MINES_W      = $clog2(MAX_CELL_WIDTH*MAX_CELL_HEIGHT/4);

  logic                    button_c_short;
  logic                    button_c_long;
  logic                    button_u;
  logic                    button_d;
  logic                    button_l;
  logic                    button_r;
  logic [CELL_X_WIDTH-1:0] field_width_i;
  logic [CELL_Y_WIDTH-1:0] field_height_i;
  logic [MINES_W-1:0]      mines_count_i;
  logic                    fill_start_o;
  logic                    fill_done_i;
  logic [3:0]              cells_state_i [MAX_CELL_WIDTH][MAX_CELL_HEIGHT];
  logic [1:0]              cells_vis_o   [MAX_CELL_WIDTH][MAX_CELL_HEIGHT];
  logic [CELL_X_WIDTH-1:0] player_x_o;
  logic [CELL_Y_WIDTH-1:0] player_y_o;
  logic [MINES_W-1:0]      flags_left_o;
  logic [3:0]              game_state_o;
  logic                    busy_o;

  modport slave (
    input  button_c_short, button_c_long, button_u, button_d, button_l, button_r,
    input  field_width_i, field_height_i, mines_count_i, fill_done_i, cells_state_i,
    output fill_start_o, cells_vis_o, player_x_o, player_y_o, flags_left_o,
    output game_state_o, busy_o
  );

  modport master (
    output button_c_short, button_c_long, button_u, button_d, button_l, button_r,
    output field_width_i, field_height_i, mines_count_i, fill_done_i, cells_state_i,
    input  fill_start_o, cells_vis_o, player_x_o, player_y_o, flags_left_o,
    input  game_state_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/minesweeper_ctrl.sv
//----------------------------------------------------------------------------
// minesweeper_ctrl : gameplay controller - cursor, flag/open, iterative flood
//                    open of zero cells, win/lose. Optional MINESWEEPER_REVEAL_EN
//                    opens every mine after a loss.
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module minesweeper_ctrl #(
  parameter int MAX_CELL_WIDTH  = 30,
  parameter int MAX_CELL_HEIGHT = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  minesweeper_ctrl_if.slave bus
);
  localparam int CELL_X_WIDTH = $clog2(MAX_CELL_WIDTH);
  localparam int CELL_Y_WIDTH = $clog2(MAX_CELL_HEIGHT);
  localparam int MINES_W      = $clog2(MAX_CELL_WIDTH*MAX_CELL_HEIGHT/4);
  localparam int CNT_W        = $clog2(MAX_CELL_WIDTH*MAX_CELL_HEIGHT+1);

  localparam logic [1:0] V_CLOSE = 2'd0;
  localparam logic [1:0] V_OPEN  = 2'd1;
  localparam logic [1:0] V_FLAG  = 2'd2;
  localparam logic [3:0] MINE    = 4'd10;

  typedef enum logic [3:0] {
    S_GAME_START  = 4'd0,
    S_FIELD_GEN   = 4'd1,
    S_IDLE        = 4'd2,
    S_CURSOR_MOVE = 4'd3,
    S_FLAG_PUT    = 4'd4,
    S_OPEN_CELL   = 4'd5,
    S_FLOOD       = 4'd6,
    S_CHECK_WIN   = 4'd7,
    S_GAME_WIN    = 4'd8,
    S_GAME_LOSE   = 4'd9,
    S_REVEAL      = 4'd10
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [CELL_X_WIDTH-1:0] r_w;
  logic [CELL_Y_WIDTH-1:0] r_h;
  logic [MINES_W-1:0]      r_mines;
  logic [CELL_X_WIDTH-1:0] r_x;
  logic [CELL_Y_WIDTH-1:0] r_y;
  logic [MINES_W-1:0]      r_flags_left;
  logic [CNT_W-1:0]        r_open_cnt;
  logic [1:0]              r_vis [MAX_CELL_WIDTH][MAX_CELL_HEIGHT];
  logic                    r_fill_start;
  logic [CELL_X_WIDTH-1:0] r_sx;
  logic [CELL_Y_WIDTH-1:0] r_sy;
  logic                    r_changed;
  logic [3:0]              r_move;      // {l, r, d, u} captured in IDLE

  logic                    w_any_move;
  logic [1:0]              w_cur_vis;
  logic [3:0]              w_cur_val;
  logic [1:0]              w_sw_vis;
  logic [3:0]              w_sw_val;
  logic                    w_sw_xlast;
  logic                    w_sw_last;
  logic                    w_nbr_zero;
  logic                    w_flood_open;
  logic [CNT_W-1:0]        w_safe;

  assign w_any_move   = bus.button_u | bus.button_d | bus.button_l | bus.button_r;
  assign w_cur_vis    = r_vis[r_x][r_y];
  assign w_cur_val    = bus.cells_state_i[r_x][r_y];
  assign w_sw_vis     = r_vis[r_sx][r_sy];
  assign w_sw_val     = bus.cells_state_i[r_sx][r_sy];
  assign w_sw_xlast   = (r_sx == r_w - 1'b1);
  assign w_sw_last    = w_sw_xlast && (r_sy == r_h - 1'b1);
  assign w_flood_open = (r_state == S_FLOOD) && (w_sw_vis == V_CLOSE) &&
                        (w_sw_val != MINE) && w_nbr_zero;
  assign w_safe       = CNT_W'(r_w) * CNT_W'(r_h) - CNT_W'(r_mines);

  // Any in-field 8-neighbour of the sweep cell that is open and has no adjacent mines
  always_comb begin : p_nbr
    int nx;
    int ny;
    nx         = 0;
    ny         = 0;
    w_nbr_zero = 1'b0;
    for (int dx = -1; dx <= 1; dx++) begin
      for (int dy = -1; dy <= 1; dy++) begin
        nx = int'(r_sx) + dx;
        ny = int'(r_sy) + dy;
        if ((dx != 0 || dy != 0) && nx >= 0 && ny >= 0 &&
            nx < int'(r_w) && ny < int'(r_h) &&
            nx < MAX_CELL_WIDTH && ny < MAX_CELL_HEIGHT) begin
          if (r_vis[nx[CELL_X_WIDTH-1:0]][ny[CELL_Y_WIDTH-1:0]] == V_OPEN &&
              bus.cells_state_i[nx[CELL_X_WIDTH-1:0]][ny[CELL_Y_WIDTH-1:0]] == 4'd0)
            w_nbr_zero = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_GAME_START;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_GAME_START:  if (bus.button_c_short) w_next = S_FIELD_GEN;
      S_FIELD_GEN:   if (bus.fill_done_i) w_next = S_IDLE;
      S_IDLE: begin
        if (w_any_move)              w_next = S_CURSOR_MOVE;
        else if (bus.button_c_long)  w_next = S_OPEN_CELL;
        else if (bus.button_c_short) w_next = S_FLAG_PUT;
      end
      S_CURSOR_MOVE: w_next = S_IDLE;
      S_FLAG_PUT:    w_next = S_IDLE;
      S_OPEN_CELL: begin
        if (w_cur_vis != V_CLOSE) w_next = S_IDLE;
`ifdef MINESWEEPER_REVEAL_EN
        else if (w_cur_val == MINE) w_next = S_REVEAL;
`else
        else if (w_cur_val == MINE) w_next = S_GAME_LOSE;
`endif
        else if (w_cur_val == 4'd0) w_next = S_FLOOD;
        else                        w_next = S_CHECK_WIN;
      end
      S_FLOOD:       if (w_sw_last) w_next = (r_changed || w_flood_open) ? S_FLOOD : S_CHECK_WIN;
      S_CHECK_WIN:   w_next = (r_open_cnt == w_safe) ? S_GAME_WIN : S_IDLE;
      S_GAME_WIN:    if (bus.button_c_short) w_next = S_GAME_START;
      S_GAME_LOSE:   if (bus.button_c_short) w_next = S_GAME_START;
`ifdef MINESWEEPER_REVEAL_EN
      S_REVEAL:      if (w_sw_last) w_next = S_GAME_LOSE;
`else
      S_REVEAL:      w_next = S_GAME_LOSE;
`endif
      default:       w_next = S_GAME_START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < MAX_CELL_WIDTH; i++)
        for (int j = 0; j < MAX_CELL_HEIGHT; j++)
          r_vis[i][j] <= V_CLOSE;
      r_w          <= '0;
      r_h          <= '0;
      r_mines      <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_flags_left <= '0;
      r_open_cnt   <= '0;
      r_fill_start <= 1'b0;
      r_sx         <= '0;
      r_sy         <= '0;
      r_changed    <= 1'b0;
      r_move       <= '0;
    end else begin
      r_fill_start <= (r_state == S_GAME_START) && bus.button_c_short;
      case (r_state)
        S_GAME_START: begin
          for (int i = 0; i < MAX_CELL_WIDTH; i++)
            for (int j = 0; j < MAX_CELL_HEIGHT; j++)
              r_vis[i][j] <= V_CLOSE;
          r_open_cnt <= '0;
          if (bus.button_c_short) begin
            r_w     <= bus.field_width_i;
            r_h     <= bus.field_height_i;
            r_mines <= bus.mines_count_i;
          end
        end
        S_FIELD_GEN: begin
          if (bus.fill_done_i) begin
            r_x          <= r_w >> 1;
            r_y          <= r_h >> 1;
            r_flags_left <= r_mines;
          end
        end
        S_IDLE: r_move <= {bus.button_l, bus.button_r, bus.button_d, bus.button_u};
        S_CURSOR_MOVE: begin
          if (r_move[3])      r_x <= (r_x == '0) ? r_w - 1'b1 : r_x - 1'b1;
          else if (r_move[2]) r_x <= (r_x == r_w - 1'b1) ? '0 : r_x + 1'b1;
          if (r_move[1])      r_y <= (r_y == '0) ? r_h - 1'b1 : r_y - 1'b1;
          else if (r_move[0]) r_y <= (r_y == r_h - 1'b1) ? '0 : r_y + 1'b1;
        end
        S_FLAG_PUT: begin
          if (w_cur_vis == V_CLOSE && r_flags_left != '0) begin
            r_vis[r_x][r_y] <= V_FLAG;
            r_flags_left    <= r_flags_left - 1'b1;
          end else if (w_cur_vis == V_FLAG) begin
            r_vis[r_x][r_y] <= V_CLOSE;
            r_flags_left    <= r_flags_left + 1'b1;
          end
        end
        S_OPEN_CELL: begin
          if (w_cur_vis == V_CLOSE) begin
            r_vis[r_x][r_y] <= V_OPEN;
            r_open_cnt      <= r_open_cnt + 1'b1;
          end
          r_sx      <= '0;
          r_sy      <= '0;
          r_changed <= 1'b0;
        end
        S_FLOOD: begin
          if (w_flood_open) begin
            r_vis[r_sx][r_sy] <= V_OPEN;
            r_open_cnt        <= r_open_cnt + 1'b1;
          end
          r_changed <= w_sw_last ? 1'b0 : (r_changed | w_flood_open);
          if (w_sw_xlast) begin
            r_sx <= '0;
            r_sy <= w_sw_last ? '0 : r_sy + 1'b1;
          end else begin
            r_sx <= r_sx + 1'b1;
          end
        end
`ifdef MINESWEEPER_REVEAL_EN
        S_REVEAL: begin
          if (w_sw_val == MINE) r_vis[r_sx][r_sy] <= V_OPEN;
          if (w_sw_xlast) begin
            r_sx <= '0;
            r_sy <= w_sw_last ? '0 : r_sy + 1'b1;
          end else begin
            r_sx <= r_sx + 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.fill_start_o = r_fill_start;
  assign bus.cells_vis_o  = r_vis;
  assign bus.player_x_o   = r_x;
  assign bus.player_y_o   = r_y;
  assign bus.flags_left_o = r_flags_left;
  assign bus.game_state_o = r_state;
  assign bus.busy_o       = (r_state == S_FIELD_GEN) || (r_state == S_FLOOD) ||
                            (r_state == S_CHECK_WIN) || (r_state == S_REVEAL);

endmodule

`default_nettype wire

// File: tb/tb_minesweeper_ctrl.sv
//----------------------------------------------------------------------------
// tb_minesweeper_ctrl : directed checks of the minesweeper controller on a
//                       4x4 field with one mine at (3,3).
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_minesweeper_ctrl;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  minesweeper_ctrl_if bus ();
  minesweeper_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // buttons: {c_short, c_long, u, d, l, r}
  localparam logic [5:0] B_S = 6'b100000;
  localparam logic [5:0] B_L = 6'b010000;
  localparam logic [5:0] B_U = 6'b001000;
  localparam logic [5:0] B_D = 6'b000100;
  localparam logic [5:0] B_LT = 6'b000010;
  localparam logic [5:0] B_RT = 6'b000001;

  typedef struct {
    logic [5:0] btn;
    int         emid;   // state one cycle after the press
    int         ex;
    int         ey;
    int         efl;
    int         evis;   // visibility of the cell under the cursor afterwards
  } vec_t;

  vec_t tbl [19];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic press(input logic [5:0] b);
    {bus.button_c_short, bus.button_c_long, bus.button_u,
     bus.button_d, bus.button_l, bus.button_r} = b;
    step();
    {bus.button_c_short, bus.button_c_long, bus.button_u,
     bus.button_d, bus.button_l, bus.button_r} = 6'b0;
  endtask

  task automatic count_vis(input logic [1:0] v, output int n);
    n = 0;
    for (int i = 0; i < 30; i++)
      for (int j = 0; j < 16; j++)
        if (bus.cells_vis_o[i][j] == v) n++;
  endtask

  task automatic start_game();
    int pulses;
    press(B_S);
    chk("start_state", int'(bus.game_state_o), 1);
    chk("start_busy", int'(bus.busy_o), 1);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus.fill_start_o) pulses++;
      step();
    end
    chk("fill_start_pulses", pulses, 1);
    bus.fill_done_i = 1'b1;
    step();
    bus.fill_done_i = 1'b0;
    chk("gen_state", int'(bus.game_state_o), 2);
    chk("gen_px", int'(bus.player_x_o), 2);
    chk("gen_py", int'(bus.player_y_o), 2);
    chk("gen_flags", int'(bus.flags_left_o), 1);
  endtask

  initial begin
    int n;
    int cyc;
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b0;
    {bus.button_c_short, bus.button_c_long, bus.button_u,
     bus.button_d, bus.button_l, bus.button_r} = 6'b0;
    bus.fill_done_i    = 1'b0;
    bus.field_width_i  = 5'd4;
    bus.field_height_i = 4'd4;
    bus.mines_count_i  = 7'd1;
    for (int i = 0; i < 30; i++)
      for (int j = 0; j < 16; j++)
        bus.cells_state_i[i][j] = 4'd0;
    bus.cells_state_i[3][3] = 4'd10;
    bus.cells_state_i[2][2] = 4'd1;
    bus.cells_state_i[2][3] = 4'd1;
    bus.cells_state_i[3][2] = 4'd1;

    // cursor starts at (2,2); flags_left starts at 1
    tbl[0]  = '{B_LT,      3, 1, 2, 1, 0};
    tbl[1]  = '{B_D,       3, 1, 1, 1, 0};
    tbl[2]  = '{B_LT,      3, 0, 1, 1, 0};
    tbl[3]  = '{B_D,       3, 0, 0, 1, 0};
    tbl[4]  = '{B_LT,      3, 3, 0, 1, 0};
    tbl[5]  = '{B_D,       3, 3, 3, 1, 0};
    tbl[6]  = '{B_RT,      3, 0, 3, 1, 0};
    tbl[7]  = '{B_U,       3, 0, 0, 1, 0};
    tbl[8]  = '{B_LT|B_U,  3, 3, 1, 1, 0};
    tbl[9]  = '{B_RT,      3, 0, 1, 1, 0};
    tbl[10] = '{B_RT,      3, 1, 1, 1, 0};
    tbl[11] = '{B_S,       4, 1, 1, 0, 2};
    tbl[12] = '{B_S,       4, 1, 1, 1, 0};
    tbl[13] = '{B_S,       4, 1, 1, 0, 2};
    tbl[14] = '{B_RT,      3, 2, 1, 0, 0};
    tbl[15] = '{B_S,       4, 2, 1, 0, 0};
    tbl[16] = '{B_LT,      3, 1, 1, 0, 2};
    tbl[17] = '{B_L,       5, 1, 1, 0, 2};
    tbl[18] = '{B_S,       4, 1, 1, 1, 0};

    step();
    step();
    chk("rst_state", int'(bus.game_state_o), 0);
    chk("rst_px", int'(bus.player_x_o), 0);
    chk("rst_py", int'(bus.player_y_o), 0);
    chk("rst_flags", int'(bus.flags_left_o), 0);
    chk("rst_busy", int'(bus.busy_o), 0);
    chk("rst_fill_start", int'(bus.fill_start_o), 0);
    count_vis(2'd0, n);
    chk("rst_vis_close", n, 480);
    rst = 1'b1;
    step();

    // idle pulses outside IDLE/START are ignored: none here, start the game
    start_game();

    // position must not change until the cycle after CURSOR_MOVE
    press(B_LT);
    chk("move_mid_px", int'(bus.player_x_o), 2);
    step();
    chk("move_done_px", int'(bus.player_x_o), 1);
    press(B_RT);
    step();

    for (int k = 0; k < 19; k++) begin
      press(tbl[k].btn);
      chk($sformatf("vec%0d_mid", k), int'(bus.game_state_o), tbl[k].emid);
      step();
      chk($sformatf("vec%0d_state", k), int'(bus.game_state_o), 2);
      chk($sformatf("vec%0d_px", k), int'(bus.player_x_o), tbl[k].ex);
      chk($sformatf("vec%0d_py", k), int'(bus.player_y_o), tbl[k].ey);
      chk($sformatf("vec%0d_flags", k), int'(bus.flags_left_o), tbl[k].efl);
      chk($sformatf("vec%0d_vis", k),
          int'(bus.cells_vis_o[bus.player_x_o][bus.player_y_o]), tbl[k].evis);
    end

    // flood from (0,0): two sweeps of 16 cycles, then win
    press(B_LT); step();
    press(B_D);  step();
    chk("flood_px", int'(bus.player_x_o), 0);
    chk("flood_py", int'(bus.player_y_o), 0);
    press(B_L);
    chk("flood_open_state", int'(bus.game_state_o), 5);
    step();
    cyc = 0;
    while (bus.game_state_o == 4'd6 && cyc < 100) begin
      cyc++;
      step();
    end
    chk("flood_cycles", cyc, 32);
    chk("flood_check_state", int'(bus.game_state_o), 7);
    chk("flood_check_busy", int'(bus.busy_o), 1);
    step();
    chk("win_state", int'(bus.game_state_o), 8);
    chk("win_busy", int'(bus.busy_o), 0);
    count_vis(2'd1, n);
    chk("win_open_count", n, 15);
    chk("win_mine_closed", int'(bus.cells_vis_o[3][3]), 0);
    chk("win_outside_closed", int'(bus.cells_vis_o[4][0]), 0);
    chk("win_corner_open", int'(bus.cells_vis_o[3][0]), 1);
    press(B_LT);
    step();
    chk("win_frozen_state", int'(bus.game_state_o), 8);
    chk("win_frozen_px", int'(bus.player_x_o), 0);
    press(B_S);
    chk("win_restart_state", int'(bus.game_state_o), 0);
    step();
    count_vis(2'd0, n);
    chk("restart_vis_close", n, 480);

    // second game: open a digit, then the mine
    start_game();
    press(B_L);
    chk("digit_open_state", int'(bus.game_state_o), 5);
    step();
    chk("digit_check_state", int'(bus.game_state_o), 7);
    step();
    chk("digit_idle_state", int'(bus.game_state_o), 2);
    chk("digit_vis", int'(bus.cells_vis_o[2][2]), 1);
    press(B_RT); step();
    press(B_U);  step();
    press(B_L);
    step();
`ifdef MINESWEEPER_REVEAL_EN
    cyc = 0;
    while (bus.game_state_o == 4'd10 && cyc < 100) begin
      cyc++;
      step();
    end
    chk("reveal_cycles", cyc, 16);
`endif
    chk("lose_state", int'(bus.game_state_o), 9);
    chk("lose_mine_open", int'(bus.cells_vis_o[3][3]), 1);
    chk("lose_other_closed", int'(bus.cells_vis_o[0][0]), 0);
    press(B_S);
    step();
    chk("lose_restart_state", int'(bus.game_state_o), 0);
    count_vis(2'd0, n);
    chk("lose_restart_vis", n, 480);

    // reset in the middle of a flood
    start_game();
    press(B_LT); step();
    press(B_LT); step();
    press(B_D);  step();
    press(B_D);  step();
    press(B_L);
    for (int k = 0; k < 5; k++) step();
    chk("midflood_state", int'(bus.game_state_o), 6);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rstflood_state", int'(bus.game_state_o), 0);
    chk("rstflood_busy", int'(bus.busy_o), 0);
    chk("rstflood_px", int'(bus.player_x_o), 0);
    chk("rstflood_flags", int'(bus.flags_left_o), 0);
    count_vis(2'd0, n);
    chk("rstflood_vis", n, 480);

    // open counter must be back at zero: a full win needs exactly 15 opens again
    start_game();
    press(B_LT); step();
    press(B_LT); step();
    press(B_D);  step();
    press(B_D);  step();
    press(B_L);
    step();
    cyc = 0;
    while (bus.game_state_o != 4'd8 && bus.game_state_o != 4'd2 && cyc < 100) begin
      cyc++;
      step();
    end
    chk("rewin_state", int'(bus.game_state_o), 8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

`default_nettype wire
